// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle controller: FSM states, opcode map,
// ALU/PC-source encodings and the packed control-word layout.
package mctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_LW      = 3'd0,
        CLS_SW      = 3'd1,
        CLS_RTYPE   = 3'd2,
        CLS_BEQ     = 3'd3,
        CLS_BNE     = 3'd4,
        CLS_JMP     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    localparam logic [3:0] OP_LW       = 4'b0000;
    localparam logic [3:0] OP_SW       = 4'b0001;
    localparam logic [3:0] OP_RTYPE_LO = 4'b0010;
    localparam logic [3:0] OP_RTYPE_HI = 4'b1001;
    localparam logic [3:0] OP_BEQ      = 4'b1011;
    localparam logic [3:0] OP_BNE      = 4'b1100;
    localparam logic [3:0] OP_JMP      = 4'b1101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic op_class_e decode_op(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_BNE:  cls = CLS_BNE;
            OP_JMP:  cls = CLS_JMP;
            default: begin
                if ((op >= OP_RTYPE_LO) && (op <= OP_RTYPE_HI)) begin
                    cls = CLS_RTYPE;
                end else begin
                    cls = CLS_ILLEGAL;
                end
            end
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait-cycle counter: counts enabled cycles, saturates at TIMEOUT and
// flags expiry while held there.
module mctrl_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_r;

    // Wait counter; saturating so a held expiry cannot wrap back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with memory
// wait timeout. Optional MCTRL_PERF_EN adds a 16-bit retired-instruction count.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       fault
`ifdef MCTRL_PERF_EN
    ,
    output logic [15:0] retired
`endif
);

    import mctrl_pkg::*;

    state_e    state_r;
    state_e    next_s;
    op_class_e cls_s;
    ctrl_t     ctrl_s;
    ctrl_t     ctrl_out_s;
    logic      fault_r;
    logic      fault_set_s;
    logic      timer_clr_s;
    logic      timer_en_s;
    logic      expired_s;

    assign cls_s = decode_op(opcode);

    // Timer restarts on every state change, so it is zero on entry to FETCH/MEM.
    assign timer_clr_s = (next_s != state_r);
    assign timer_en_s  = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;

    mctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Sticky fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (fault_set_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    // Next-state and control-word decode; expiry takes priority over mem_ready.
    always_comb begin
        next_s      = state_r;
        ctrl_s      = '0;
        fault_set_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                ctrl_s.mem_req = 1'b1;
                if (expired_s) begin
                    fault_set_s = 1'b1;
                    next_s      = ST_HALT;
                end else if (mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                    ctrl_s.pc_src   = PC_INC;
                    next_s          = ST_DECODE;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (cls_s)
                    CLS_JMP: begin
                        ctrl_s.pc_write = 1'b1;
                        ctrl_s.pc_src   = PC_JUMP;
                        next_s          = ST_FETCH;
                    end
                    CLS_ILLEGAL: begin
                        ctrl_s.illegal = 1'b1;
                        next_s         = ST_FETCH;
                    end
                    default: next_s = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_LW, CLS_SW: begin
                        ctrl_s.alu_src = 1'b1;
                        ctrl_s.alu_op  = ALU_ADD;
                        next_s         = ST_MEM;
                    end
                    CLS_RTYPE: begin
                        ctrl_s.alu_op = ALU_FUNCT;
                        next_s        = ST_WB;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        ctrl_s.alu_op = ALU_SUB;
                        if ((cls_s == CLS_BEQ) == zero) begin
                            ctrl_s.pc_write = 1'b1;
                            ctrl_s.pc_src   = PC_BRANCH;
                        end else begin
                            ctrl_s.pc_write = 1'b0;
                        end
                        next_s = ST_FETCH;
                    end
                    default: next_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.iord    = 1'b1;
                ctrl_s.mem_we  = (cls_s == CLS_SW);
                if (expired_s) begin
                    fault_set_s = 1'b1;
                    next_s      = ST_HALT;
                end else if (mem_ready) begin
                    next_s = (cls_s == CLS_LW) ? ST_WB : ST_FETCH;
                end else begin
                    next_s = ST_MEM;
                end
            end
            ST_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = (cls_s == CLS_LW);
                ctrl_s.reg_dst    = (cls_s == CLS_RTYPE);
                next_s            = ST_FETCH;
            end
            ST_HALT: next_s = ST_HALT;
            default: next_s = ST_FETCH;
        endcase
    end

    // Reset forces every output low, including an in-flight memory request.
    always_comb begin
        if (rst) begin
            ctrl_out_s = '0;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign mem_req    = ctrl_out_s.mem_req;
    assign mem_we     = ctrl_out_s.mem_we;
    assign iord       = ctrl_out_s.iord;
    assign ir_write   = ctrl_out_s.ir_write;
    assign pc_write   = ctrl_out_s.pc_write;
    assign reg_write  = ctrl_out_s.reg_write;
    assign alu_src    = ctrl_out_s.alu_src;
    assign reg_dst    = ctrl_out_s.reg_dst;
    assign mem_to_reg = ctrl_out_s.mem_to_reg;
    assign alu_op     = ctrl_out_s.alu_op;
    assign pc_src     = ctrl_out_s.pc_src;
    assign illegal    = ctrl_out_s.illegal;
    assign fault      = fault_r & ~rst;

`ifdef MCTRL_PERF_EN
    logic        retire_s;
    logic [15:0] retired_r;

    assign retire_s = ((state_r == ST_DECODE) || (state_r == ST_EXEC) ||
                       (state_r == ST_MEM) || (state_r == ST_WB)) &&
                      (next_s == ST_FETCH) && !ctrl_s.illegal;

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= 16'd0;
        end else if (retire_s) begin
            retired_r <= retired_r + 16'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired = retired_r;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: one packed output vector
// is compared each cycle against hand-built expected control words.
module tb_multicycle_ctrl;

    localparam logic [14:0] B_MREQ    = 15'h4000;
    localparam logic [14:0] B_MWE     = 15'h2000;
    localparam logic [14:0] B_IORD    = 15'h1000;
    localparam logic [14:0] B_IRW     = 15'h0800;
    localparam logic [14:0] B_PCW     = 15'h0400;
    localparam logic [14:0] B_RW      = 15'h0200;
    localparam logic [14:0] B_ASRC    = 15'h0100;
    localparam logic [14:0] B_RDST    = 15'h0080;
    localparam logic [14:0] B_M2R     = 15'h0040;
    localparam logic [14:0] B_AOP_F   = 15'h0020;
    localparam logic [14:0] B_AOP_SUB = 15'h0010;
    localparam logic [14:0] B_PC_J    = 15'h0008;
    localparam logic [14:0] B_PC_BR   = 15'h0004;
    localparam logic [14:0] B_ILL     = 15'h0002;
    localparam logic [14:0] B_FLT     = 15'h0001;
    localparam logic [14:0] NONE      = 15'h0000;

    localparam logic [14:0] E_FETCH   = B_MREQ;
    localparam logic [14:0] E_FETCHED = B_MREQ | B_IRW | B_PCW;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic       alu_src, reg_dst, mem_to_reg, illegal, fault;
    logic [1:0] alu_op, pc_src;
    logic [14:0] obs_s;
`ifdef MCTRL_PERF_EN
    logic [15:0] retired;
`endif

    int vecs = 0;
    int errs = 0;

    multicycle_ctrl #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .fault      (fault)
`ifdef MCTRL_PERF_EN
        ,
        .retired    (retired)
`endif
    );

    assign obs_s = {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                    alu_src, reg_dst, mem_to_reg, alu_op, pc_src, illegal, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs in the low phase, then check outputs.
    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [14:0] exp);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
        chk(tag, {17'd0, obs_s}, {17'd0, exp});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk(tag, {17'd0, obs_s}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 4'b0000;
        zero      = 1'b0;
        mem_ready = 1'b0;

        do_reset("reset_outs");
        cyc("post_reset_fetch", 1'b0, 1'b0, E_FETCH);

        // ADD: FETCH, DECODE, EXEC, WB, back to FETCH
        opcode = 4'b0010;
        cyc("add_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("add_decode", 1'b1, 1'b0, NONE);
        cyc("add_exec", 1'b1, 1'b0, B_AOP_F);
        cyc("add_wb", 1'b1, 1'b0, B_RW | B_RDST);
        cyc("add_refetch", 1'b0, 1'b0, E_FETCH);
`ifdef MCTRL_PERF_EN
        chk("retired_after_add", {16'd0, retired}, 32'd1);
`endif

        // LW with mem_ready on the 3rd cycle in FETCH and MEM
        opcode = 4'b0000;
        cyc("lw_f_wait1", 1'b0, 1'b0, E_FETCH);
        cyc("lw_f_wait2", 1'b0, 1'b0, E_FETCH);
        cyc("lw_f_done", 1'b1, 1'b0, E_FETCHED);
        cyc("lw_decode", 1'b0, 1'b0, NONE);
        cyc("lw_exec", 1'b0, 1'b0, B_ASRC);
        cyc("lw_m_wait1", 1'b0, 1'b0, B_MREQ | B_IORD);
        cyc("lw_m_wait2", 1'b0, 1'b0, B_MREQ | B_IORD);
        cyc("lw_m_done", 1'b1, 1'b0, B_MREQ | B_IORD);
        cyc("lw_wb", 1'b1, 1'b0, B_RW | B_M2R);
        cyc("lw_refetch", 1'b0, 1'b0, E_FETCH);

        // SW, mem_ready tied high: 4 cycles
        opcode = 4'b0001;
        cyc("sw_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("sw_decode", 1'b1, 1'b0, NONE);
        cyc("sw_exec", 1'b1, 1'b0, B_ASRC);
        cyc("sw_mem", 1'b1, 1'b0, B_MREQ | B_IORD | B_MWE);
        cyc("sw_refetch", 1'b0, 1'b0, E_FETCH);

        // Branches: taken / not taken for both senses of zero
        opcode = 4'b1011;
        cyc("beq_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("beq_decode", 1'b1, 1'b0, NONE);
        cyc("beq_z1_exec", 1'b1, 1'b1, B_AOP_SUB | B_PCW | B_PC_BR);
        cyc("beq_refetch", 1'b1, 1'b0, E_FETCHED);
        cyc("beq2_decode", 1'b1, 1'b0, NONE);
        cyc("beq_z0_exec", 1'b1, 1'b0, B_AOP_SUB);
        opcode = 4'b1100;
        cyc("bne_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("bne_decode", 1'b1, 1'b0, NONE);
        cyc("bne_z1_exec", 1'b1, 1'b1, B_AOP_SUB);
        cyc("bne_refetch", 1'b1, 1'b0, E_FETCHED);
        cyc("bne2_decode", 1'b1, 1'b0, NONE);
        cyc("bne_z0_exec", 1'b1, 1'b0, B_AOP_SUB | B_PCW | B_PC_BR);

        // JMP: 2 cycles
        opcode = 4'b1101;
        cyc("jmp_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("jmp_decode", 1'b1, 1'b0, B_PCW | B_PC_J);

        // Illegal opcodes pulse illegal for one DECODE cycle
        opcode = 4'b1110;
        cyc("ill_e_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("ill_e_decode", 1'b1, 1'b0, B_ILL);
        opcode = 4'b1010;
        cyc("ill_a_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("ill_a_decode", 1'b1, 1'b0, B_ILL);
        opcode = 4'b1111;
        cyc("ill_f_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("ill_f_decode", 1'b1, 1'b0, B_ILL);
        cyc("ill_refetch", 1'b0, 1'b0, E_FETCH);

        // Timeout in MEM: 15 wait cycles, then expiry wins over mem_ready
        opcode = 4'b0001;
        cyc("to_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("to_decode", 1'b1, 1'b0, NONE);
        cyc("to_exec", 1'b1, 1'b0, B_ASRC);
        for (int i = 0; i < 15; i++) begin
            cyc("to_mem_wait", 1'b0, 1'b0, B_MREQ | B_IORD | B_MWE);
        end
        cyc("to_expire_cycle", 1'b1, 1'b0, B_MREQ | B_IORD | B_MWE);
        cyc("to_halt", 1'b1, 1'b0, B_FLT);
        cyc("to_halt_sticky", 1'b1, 1'b0, B_FLT);
        do_reset("to_reset_outs");
        cyc("to_recover_fetch", 1'b0, 1'b0, E_FETCH);

        // Reset mid-MEM during a store drops the request immediately
        opcode = 4'b0001;
        cyc("mr_fetch", 1'b1, 1'b0, E_FETCHED);
        cyc("mr_decode", 1'b1, 1'b0, NONE);
        cyc("mr_exec", 1'b1, 1'b0, B_ASRC);
        cyc("mr_mem", 1'b0, 1'b0, B_MREQ | B_IORD | B_MWE);
        rst = 1'b1;
        #1;
        chk("mr_rst_outs", {17'd0, obs_s}, 32'd0);
`ifdef MCTRL_PERF_EN
        chk("mr_retired_cleared", {16'd0, retired}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("mr_refetch", 1'b0, 1'b0, E_FETCH);
        cyc("mr_refetch_hold", 1'b0, 1'b0, E_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait on mem_ready before faulting.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port opcode, input, 4: the instruction register opcode field, stable from DECODE until the next FETCH.
REQ-005 SHALL have port zero, input, 1: ALU zero flag, valid in EXEC.
REQ-006 SHALL have port mem_ready, input, 1: completion strobe from the shared memory port.
REQ-007 SHALL have outputs mem_req, mem_we and iord, each 1 bit: memory handshake; iord=0 selects the instruction address, iord=1 the data address.
REQ-008 SHALL have outputs ir_write, pc_write, reg_write, alu_src, reg_dst and mem_to_reg, each 1 bit: datapath enables and mux selects.
REQ-009 SHALL have output alu_op, 2 bits (00 add, 01 sub, 10 R-type funct) and output pc_src, 2 bits (00 PC+2, 01 branch target, 10 jump target).
REQ-010 SHALL have output illegal, 1 bit (one-cycle pulse) and output fault, 1 bit (sticky).

Function
REQ-011 SHALL decode opcodes as: 0000 LW; 0001 SW; 0010-1001 R-type; 1011 BEQ; 1100 BNE; 1101 JMP; 1010/1110/1111 illegal.
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM, WB and HALT, with outputs combinational from state, opcode, zero and mem_ready.
REQ-013 All outputs not listed for a state SHALL be 0.
REQ-014 FETCH SHALL assert mem_req=1 with iord=0, and hold that while mem_ready=0.
REQ-015 In FETCH, on mem_ready=1 the block SHALL assert ir_write=1 and pc_write=1 (pc_src=00) for that cycle only, then go to DECODE.
REQ-016 DECODE SHALL last one cycle.
REQ-017 DECODE transitions:
- JMP: assert pc_write=1, pc_src=10, then FETCH.
- illegal opcode: pulse illegal=1, then FETCH.
- all other opcodes: EXEC.
REQ-018 EXEC for LW/SW SHALL assert alu_src=1 and alu_op=00, then go to MEM.
REQ-019 EXEC for R-type SHALL assert alu_op=10, then go to WB.
REQ-020 EXEC for BEQ/BNE SHALL assert alu_op=01 and go to FETCH; pc_write=1 with pc_src=01 only when (BEQ and zero=1) or (BNE and zero=0).
REQ-021 MEM SHALL assert mem_req=1 and iord=1, with mem_we=1 for SW, held until mem_ready=1; then LW goes to WB and SW goes to FETCH.
REQ-022 WB SHALL assert reg_write=1; mem_to_reg=1 for LW, reg_dst=1 for R-type; then FETCH.
REQ-023 A wait counter SHALL clear on entry to FETCH or MEM and count each cycle mem_ready=0 there.
REQ-024 When the wait counter reaches TIMEOUT, the block SHALL set fault=1 and enter HALT; HALT drives all other outputs 0 and is left only by reset.
REQ-025 mem_ready SHALL be ignored outside FETCH/MEM, and ignored in the same cycle the timeout fires (fault wins).
REQ-026 Minimum latency with mem_ready tied high SHALL be: JMP 2 cycles; branch 3; R-type and SW 4; LW 5.

Reset
REQ-027 rst=1 SHALL immediately force state=FETCH, clear the wait counter and clear fault, aborting any in-flight access.
REQ-028 While rst=1, all outputs SHALL be 0, including mem_req.
REQ-029 The first cycle after rst deasserts SHALL be FETCH, with mem_req=1 and iord=0.

Configuration
REQ-030 With MCTRL_PERF_EN defined, the block SHALL add output retired (16 bits), reset to 0.
REQ-031 retired SHALL increment on each return to FETCH from DECODE, EXEC, MEM or WB, excluding illegal-opcode returns, and wrap from 0xFFFF to 0x0000.
REQ-032 Without MCTRL_PERF_EN, the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-033 Package mctrl_pkg SHALL hold the state enumeration, the opcode constants, and the alu_op and pc_src encodings.
REQ-034 The wait counter SHALL be a sub-module mctrl_wait_timer (inputs clr and en, parameter TIMEOUT, output expired).

Verification
REQ-035 ADD (0010) with mem_ready=1 -> states FETCH, DECODE, EXEC, WB; reg_write=1 and reg_dst=1 in cycle 4; back in FETCH in cycle 5.
REQ-036 LW with 3-cycle mem_ready delay in both FETCH and MEM -> mem_req held 3 cycles each; iord 0 then 1; mem_to_reg=1 in WB; total 9 cycles.
REQ-037 BEQ with zero=1 -> pc_write=1 and pc_src=01 in EXEC; BNE with zero=1 -> pc_write=0 in EXEC.
REQ-038 Opcode 1110 -> illegal pulses 1 cycle in DECODE; no reg_write, no pc_write; next state FETCH.
REQ-039 mem_ready held 0 in MEM -> fault=1 after 15 wait cycles, state HALT; rst pulse -> fault=0, FETCH.
REQ-040 rst asserted mid-MEM with mem_we=1 -> mem_we and mem_req drop to 0 the same cycle; with MCTRL_PERF_EN, retired=0.
